spm_ex_loader: RTL and testbench

//  External-side loader that drives the scratchpad ex_bus {wen, ren, addr, data}.
//  - Accepts one transfer command at a time: base address, word count and stride.
//  - WRITE commands move an input word stream into the bank groups, one word per beat.
//  - READ commands issue read-enable beats; read data returns on the bank-group outputs.
//  - Sits directly upstream of the scratchpad ex_bus input.

---
 rtl/spm_ex_loader_if.sv | 31 +++
 rtl/spm_ex_loader.sv | 108 ++++++++++
 tb/tb_spm_ex_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spm_ex_loader_if.sv
// Command, write-stream and ex_bus signals of the scratchpad external loader.
// master = loader side, slave = command/stream source and bus observer.
interface spm_ex_loader_if #(
  parameter int A_W   = 8,
  parameter int D_W   = 32,
  parameter int LEN_W = 9
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_op;
  logic [A_W-1:0]       cmd_base;
  logic [LEN_W-1:0]     cmd_len;
  logic [A_W-1:0]       cmd_stride;
  logic                 s_valid;
  logic                 s_ready;
  logic [D_W-1:0]       s_data;
  logic [2+A_W+D_W-1:0] ex_bus;
  logic                 busy;
  logic                 done;
  logic [LEN_W-1:0]     beat_cnt;

  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, cmd_stride, s_valid, s_data,
    output cmd_ready, s_ready, ex_bus, busy, done, beat_cnt
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_len, cmd_stride, s_valid, s_data,
    input  cmd_ready, s_ready, ex_bus, busy, done, beat_cnt
  );
endinterface

// File: rtl/spm_ex_loader.sv
// External-side scratchpad loader: turns one strided transfer command at a
// time into registered ex_bus {wen, ren, addr, data} beats.
//
//  state | meaning
//  IDLE  | waiting for a command, cmd_ready high
//  WR    | one wen beat per accepted stream word, bubbles when s_valid low
//  RD    | one ren beat per cycle until the word count is exhausted
//  FIN   | completion cycle; done is raised on the following cycle
module spm_ex_loader #(
  parameter int A_W   = 8,
  parameter int D_W   = 32,
  parameter int LEN_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  spm_ex_loader_if.master bus
);

  localparam int BUS_W = 2 + A_W + D_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       r_state;
  logic [A_W-1:0]   r_addr;
  logic [A_W-1:0]   r_stride;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [BUS_W-1:0] r_ex_bus;
  logic             r_done;

  logic w_accept;
  logic w_s_ready;
  logic w_wr_beat;
  logic w_rd_beat;
  logic w_beat;
  logic w_last;

  assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
  // Remaining is never zero inside WR; the check keeps s_ready safe anyway.
  assign w_s_ready = (r_state == S_WR) && (r_remaining != '0);
  assign w_wr_beat = bus.s_valid && w_s_ready;
  assign w_rd_beat = (r_state == S_RD);
  assign w_beat    = w_wr_beat || w_rd_beat;
  assign w_last    = (r_remaining == LEN_W'(1));

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.s_ready   = w_s_ready;
  assign bus.ex_bus    = r_ex_bus;
  assign bus.done      = r_done;
  assign bus.beat_cnt  = r_beat_cnt;

  // Sequencing FSM; a zero-length command goes straight to FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.cmd_len == '0) r_state <= S_FIN;
            else if (bus.cmd_op)   r_state <= S_WR;
            else                   r_state <= S_RD;
          end
        end
        S_WR:    if (w_wr_beat && w_last) r_state <= S_FIN;
        S_RD:    if (w_last)              r_state <= S_FIN;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Command latch plus address/remaining/beat counters; address wraps modulo 2^A_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
    end else if (w_accept) begin
      r_addr      <= bus.cmd_base;
      r_stride    <= bus.cmd_stride;
      r_remaining <= bus.cmd_len;
      r_beat_cnt  <= '0;
    end else if (w_beat) begin
      r_addr      <= r_addr + r_stride;
      r_remaining <= r_remaining - LEN_W'(1);
      r_beat_cnt  <= r_beat_cnt + LEN_W'(1);
    end
  end

  // Registered bus beat (zero when idle or stalled) and the done pulse after FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_bus <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      if (w_wr_beat)      r_ex_bus <= {2'b10, r_addr, bus.s_data};
      else if (w_rd_beat) r_ex_bus <= {2'b01, r_addr, {D_W{1'b0}}};
      else                r_ex_bus <= '0;
    end
  end

endmodule

// File: tb/tb_spm_ex_loader.sv
// Directed and randomized commands checked cycle by cycle against a
// transfer-level model: beat i of a command targets base + i*stride (mod 256),
// write beats follow their stream handshake by one cycle, read beats start two
// cycles after accept, and done follows the last beat by one cycle.
module tb_spm_ex_loader;
  localparam int A_W   = 8;
  localparam int D_W   = 32;
  localparam int LEN_W = 9;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spm_ex_loader_if #(.A_W(A_W), .D_W(D_W), .LEN_W(LEN_W)) bus_if ();

  spm_ex_loader #(.A_W(A_W), .D_W(D_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_junk_cmd();
    bus_if.cmd_valid  = 1'($urandom_range(0, 1));
    bus_if.cmd_op     = 1'($urandom_range(0, 1));
    bus_if.cmd_base   = 8'($urandom);
    bus_if.cmd_len    = 9'($urandom_range(0, 300));
    bus_if.cmd_stride = 8'($urandom);
  endtask

  // vmode: 0 = s_valid always high, 1 = pattern 1,0,1,1,..., 2 = random.
  // abort_after >= 0 asserts rst once that many beats have been observed.
  task automatic do_cmd(input bit op, input logic [7:0] base, input int len,
                        input logic [7:0] stride, input int vmode, input bit dseq,
                        input int abort_after);
    int          k;
    int          beats_seen;
    int          done_cycle;
    bit          valid;
    logic [41:0] exp_bus;
    logic [41:0] nxt_bus;
    logic [31:0] d;

    chk("cmd_ready_at_accept", {63'b0, bus_if.cmd_ready}, 64'd1);
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_op     = op;
    bus_if.cmd_base   = base;
    bus_if.cmd_len    = 9'(len);
    bus_if.cmd_stride = stride;
    bus_if.s_valid    = 1'b0;
    k          = 0;
    beats_seen = 0;
    exp_bus    = '0;
    if (len == 0)  done_cycle = 2;
    else if (op)   done_cycle = 1000000;
    else           done_cycle = len + 2;

    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (exp_bus != '0) beats_seen++;
      chk("ex_bus",    64'(bus_if.ex_bus),   64'(exp_bus));
      chk("beat_cnt",  64'(bus_if.beat_cnt), 64'(beats_seen));
      chk("done",      64'(bus_if.done),     64'(c == done_cycle));
      chk("busy",      64'(bus_if.busy),     64'(c < done_cycle));
      chk("cmd_ready", 64'(bus_if.cmd_ready), 64'(c >= done_cycle));
      if (c == done_cycle) begin
        chk("final_beat_cnt", 64'(bus_if.beat_cnt), 64'(len));
        return;
      end
      if (abort_after >= 0 && beats_seen == abort_after) begin
        rst = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.s_valid   = 1'b0;
        @(negedge clk);
        chk("abort_ex_bus",    64'(bus_if.ex_bus),    64'd0);
        chk("abort_busy",      64'(bus_if.busy),      64'd0);
        chk("abort_done",      64'(bus_if.done),      64'd0);
        chk("abort_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        chk("abort_beat_cnt",  64'(bus_if.beat_cnt),  64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done",   64'(bus_if.done),      64'd0);
        chk("abort_idle",      64'(bus_if.busy),      64'd0);
        return;
      end
      drive_junk_cmd();
      nxt_bus = '0;
      if (op) begin
        chk("s_ready_wr", 64'(bus_if.s_ready), 64'(k < len));
        case (vmode)
          0:       valid = 1'b1;
          1:       valid = (c != 2);
          default: valid = 1'($urandom_range(0, 1));
        endcase
        d = dseq ? 32'hA0 + 32'(k) : $urandom;
        bus_if.s_valid = valid;
        bus_if.s_data  = d;
        if (valid && k < len) begin
          nxt_bus = {1'b1, 1'b0, 8'(32'(base) + k * 32'(stride)), d};
          k++;
          if (k == len) done_cycle = c + 2;
        end
      end else begin
        chk("s_ready_rd", 64'(bus_if.s_ready), 64'd0);
        bus_if.s_valid = 1'($urandom_range(0, 1));
        bus_if.s_data  = $urandom;
        if (c - 1 < len) nxt_bus = {1'b0, 1'b1, 8'(32'(base) + (c - 1) * 32'(stride)), 32'h0};
      end
      exp_bus = nxt_bus;
    end
    checks++;
    failures++;
    $display("FAIL cmd_timeout observed=no_done expected=done_within_3000_cycles");
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_op     = 1'b0;
    bus_if.cmd_base   = '0;
    bus_if.cmd_len    = '0;
    bus_if.cmd_stride = '0;
    bus_if.s_valid    = 1'b0;
    bus_if.s_data     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ex_bus",    64'(bus_if.ex_bus),    64'd0);
    chk("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    chk("rst_busy",      64'(bus_if.busy),      64'd0);
    chk("rst_done",      64'(bus_if.done),      64'd0);
    chk("rst_beat_cnt",  64'(bus_if.beat_cnt),  64'd0);
    chk("rst_s_ready",   64'(bus_if.s_ready),   64'd0);
    rst = 1'b0;

    do_cmd(1'b1, 8'h10, 4, 8'h01, 0, 1'b1, -1);
    do_cmd(1'b1, 8'h40, 3, 8'h01, 1, 1'b0, -1);
    do_cmd(1'b0, 8'hFE, 4, 8'h01, 0, 1'b0, -1);
    do_cmd(1'b1, 8'h33, 0, 8'h05, 0, 1'b0, -1);
    do_cmd(1'b0, 8'h20, 2, 8'h00, 0, 1'b0, -1);
    do_cmd(1'b0, 8'h80, 8, 8'h01, 0, 1'b0, 2);
    do_cmd(1'b1, 8'hF0, 5, 8'h07, 2, 1'b0, -1);
    do_cmd(1'b0, 8'h00, 256, 8'h01, 0, 1'b0, -1);

    for (int n = 0; n < 25; n++) begin
      do_cmd(1'($urandom_range(0, 1)), 8'($urandom),
             ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16)),
             ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
             2, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
